// File: rtl/mac_array_ws_pkg.sv
// mac_array_pkg: shared definitions for the weight-stationary MAC array.
//   state_t  - control FSM states
//   calc_lat - accept-to-result latency of a MAC_ROW x MAC_COL array
package mac_array_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,  // no active weights yet
    ST_ACTIVE = 2'd1,  // streaming activations
    ST_DRAIN  = 2'd2,  // tile ended, waiting for in-flight vectors
    ST_SWAP   = 2'd3   // shadow bank copied into active bank this cycle
  } state_t;

  // One cycle per PE hop down a column and across a row: skew plus array
  // depth plus deskew plus the output register.
  function automatic int calc_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/mac_array_ws_if.sv
// mac_array_ws_if: streaming bus of the MAC array.
//   weight load : w_load_valid/w_load_ready/w_load_data (one weight row/beat)
//   activations : ifmap_valid/ifmap_ready/ifmap_data/ifmap_last
//   results     : ofmap_valid/ofmap_data/ofmap_last (no backpressure), busy
// slave = the array, master = the producer/consumer.
interface mac_array_ws_if #(
  parameter int MAC_ROW        = 16,
  parameter int MAC_COL        = 16,
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32
);
  logic                                w_load_valid;
  logic                                w_load_ready;
  logic [MAC_COL*W_BITWIDTH-1:0]       w_load_data;
  logic                                ifmap_valid;
  logic                                ifmap_ready;
  logic [MAC_ROW*IFMAP_BITWIDTH-1:0]   ifmap_data;
  logic                                ifmap_last;
  logic                                ofmap_valid;
  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_data;
  logic                                ofmap_last;
  logic                                busy;

  modport slave (
    input  w_load_valid, w_load_data, ifmap_valid, ifmap_data, ifmap_last,
    output w_load_ready, ifmap_ready, ofmap_valid, ofmap_data, ofmap_last, busy
  );

  modport master (
    output w_load_valid, w_load_data, ifmap_valid, ifmap_data, ifmap_last,
    input  w_load_ready, ifmap_ready, ofmap_valid, ofmap_data, ofmap_last, busy
  );
endinterface

// File: rtl/mac_array_ws_pe.sv
// mac_pe: one processing element of the weight-stationary array.
//   i_w_load/i_w_data : write the shadow weight
//   i_swap            : copy shadow weight into the active weight
//   i_act/i_valid     : activation (and its valid) from the west, passed east
//   i_psum/o_psum     : partial sum from the north, accumulated and passed south
module mac_pe #(
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32,
  parameter int SATURATE       = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_w_load,
  input  logic signed [W_BITWIDTH-1:0]     i_w_data,
  input  logic                             i_swap,
  input  logic signed [IFMAP_BITWIDTH-1:0] i_act,
  input  logic                             i_valid,
  input  logic signed [OFMAP_BITWIDTH-1:0] i_psum,
  output logic signed [IFMAP_BITWIDTH-1:0] o_act,
  output logic                             o_valid,
  output logic signed [OFMAP_BITWIDTH-1:0] o_psum
);
  localparam int PW = IFMAP_BITWIDTH + W_BITWIDTH;
  // One guard bit above the wider of product and partial sum so the
  // addition never overflows before clamping.
  localparam int SW = ((OFMAP_BITWIDTH > PW) ? OFMAP_BITWIDTH : PW) + 1;
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-OFMAP_BITWIDTH+1){1'b0}}, {(OFMAP_BITWIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-OFMAP_BITWIDTH+1){1'b1}}, {(OFMAP_BITWIDTH-1){1'b0}}};

  logic signed [W_BITWIDTH-1:0]     r_w_shadow;
  logic signed [W_BITWIDTH-1:0]     r_w_active;
  logic signed [PW-1:0]             w_prod;
  logic signed [SW-1:0]             w_prod_ext;
  logic signed [SW-1:0]             w_psum_ext;
  logic signed [SW-1:0]             w_sum;
  logic signed [OFMAP_BITWIDTH-1:0] w_acc;

  assign w_prod     = i_act * r_w_active;
  assign w_prod_ext = {{(SW-PW){w_prod[PW-1]}}, w_prod};
  assign w_psum_ext = {{(SW-OFMAP_BITWIDTH){i_psum[OFMAP_BITWIDTH-1]}}, i_psum};
  assign w_sum      = w_prod_ext + w_psum_ext;

  always_comb begin
    w_acc = w_sum[OFMAP_BITWIDTH-1:0];
    if (SATURATE != 0) begin
      if (w_sum > SAT_MAX)      w_acc = SAT_MAX[OFMAP_BITWIDTH-1:0];
      else if (w_sum < SAT_MIN) w_acc = SAT_MIN[OFMAP_BITWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_w_shadow <= '0;
      r_w_active <= '0;
      o_act      <= '0;
      o_valid    <= 1'b0;
      o_psum     <= '0;
    end else begin
      if (i_w_load) r_w_shadow <= i_w_data;
      if (i_swap)   r_w_active <= r_w_shadow;
      o_act   <= i_act;
      o_valid <= i_valid;
      o_psum  <= w_acc;
    end
  end
endmodule

// File: rtl/mac_array_ws.sv
// mac_array_ws: weight-stationary MAC_ROW x MAC_COL systolic array.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : mac_array_ws_if.slave (weight load, activations, results)
// Activations move east, partial sums move south. Row r is skewed by r
// cycles on entry, column c deskewed by MAC_COL-1-c cycles on exit, so a
// vector accepted at cycle t is presented at t + MAC_ROW + MAC_COL.
module mac_array_ws #(
  parameter int MAC_ROW        = 16,
  parameter int MAC_COL        = 16,
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32,
  parameter int SATURATE       = 1
) (
  input  logic           clk,
  input  logic           rstn,
  mac_array_ws_if.slave  bus
);
  import mac_array_pkg::*;

  localparam int IW  = IFMAP_BITWIDTH;
  localparam int OW  = OFMAP_BITWIDTH;
  localparam int LAT = calc_lat(MAC_ROW, MAC_COL);
  localparam int CW  = $clog2(LAT + 1);
  localparam int RW  = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;

  state_t           r_state;
  logic             r_ifmap_ready;
  logic             r_shadow_full;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_inflight;
  logic             r_ofmap_valid;
  logic             r_ofmap_last;
  logic [MAC_COL*OW-1:0] r_ofmap_data;
  logic             r_last_sr [LAT-1];

  logic             w_beat;
  logic             w_accept;
  logic             w_swap;

  logic signed [IW-1:0] w_act  [MAC_ROW][MAC_COL+1];
  logic                 w_vld  [MAC_ROW][MAC_COL+1];
  logic signed [OW-1:0] w_psum [MAC_ROW+1][MAC_COL];
  logic signed [OW-1:0] w_col_out [MAC_COL];
  logic [MAC_COL*OW-1:0] w_col_packed;

  assign w_beat   = bus.w_load_valid & ~r_shadow_full;
  assign w_accept = bus.ifmap_valid & r_ifmap_ready;
  assign w_swap   = (r_state == ST_SWAP);

  assign bus.w_load_ready = ~r_shadow_full;
  assign bus.ifmap_ready  = r_ifmap_ready;
  assign bus.ofmap_valid  = r_ofmap_valid;
  assign bus.ofmap_last   = r_ofmap_last;
  assign bus.ofmap_data   = r_ofmap_data;
  assign bus.busy         = (r_state != ST_EMPTY) | (r_inflight != '0);

  // Shadow bank row pointer; a full bank blocks further beats until swap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_row         <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      if (w_swap) r_shadow_full <= 1'b0;
      if (w_beat) begin
        if (r_row == RW'(MAC_ROW - 1)) begin
          r_row         <= '0;
          r_shadow_full <= 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_inflight <= '0;
    end else if (w_accept && !r_ofmap_valid) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_accept && r_ofmap_valid) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_EMPTY;
      r_ifmap_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (r_shadow_full && r_inflight == '0) r_state <= ST_SWAP;
        ST_SWAP: begin
          r_state       <= ST_ACTIVE;
          r_ifmap_ready <= 1'b1;
        end
        ST_ACTIVE: if (w_accept && bus.ifmap_last) begin
          r_state       <= ST_DRAIN;
          r_ifmap_ready <= 1'b0;
        end
        ST_DRAIN: if (r_inflight == '0) begin
          if (r_shadow_full) begin
            r_state <= ST_SWAP;
          end else begin
            r_state       <= ST_ACTIVE;
            r_ifmap_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_EMPTY;
          r_ifmap_ready <= 1'b0;
        end
      endcase
    end
  end

  genvar gi, gj;

  // Input skew. Data is zeroed on bubbles so idle slots accumulate nothing.
  for (gi = 0; gi < MAC_ROW; gi++) begin : g_skew
    logic signed [IW-1:0] w_in;
    assign w_in = w_accept ? bus.ifmap_data[gi*IW +: IW] : '0;
    if (gi == 0) begin : g_direct
      assign w_act[0][0] = w_in;
      assign w_vld[0][0] = w_accept;
    end else begin : g_dly
      logic signed [IW-1:0] r_sd [gi];
      logic                 r_sv [gi];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < gi; k++) begin
            r_sd[k] <= '0;
            r_sv[k] <= 1'b0;
          end
        end else begin
          r_sd[0] <= w_in;
          r_sv[0] <= w_accept;
          for (int k = 1; k < gi; k++) begin
            r_sd[k] <= r_sd[k-1];
            r_sv[k] <= r_sv[k-1];
          end
        end
      end
      assign w_act[gi][0] = r_sd[gi-1];
      assign w_vld[gi][0] = r_sv[gi-1];
    end
  end

  for (gj = 0; gj < MAC_COL; gj++) begin : g_top
    assign w_psum[0][gj] = '0;
  end

  for (gi = 0; gi < MAC_ROW; gi++) begin : g_row
    for (gj = 0; gj < MAC_COL; gj++) begin : g_col
      mac_pe #(
        .IFMAP_BITWIDTH (IFMAP_BITWIDTH),
        .W_BITWIDTH     (W_BITWIDTH),
        .OFMAP_BITWIDTH (OFMAP_BITWIDTH),
        .SATURATE       (SATURATE)
      ) u_pe (
        .clk      (clk),
        .rstn     (rstn),
        .i_w_load (w_beat && (r_row == RW'(gi))),
        .i_w_data (bus.w_load_data[gj*W_BITWIDTH +: W_BITWIDTH]),
        .i_swap   (w_swap),
        .i_act    (w_act[gi][gj]),
        .i_valid  (w_vld[gi][gj]),
        .i_psum   (w_psum[gi][gj]),
        .o_act    (w_act[gi][gj+1]),
        .o_valid  (w_vld[gi][gj+1]),
        .o_psum   (w_psum[gi+1][gj])
      );
    end
  end

  // Output deskew: early columns wait for the last column.
  for (gj = 0; gj < MAC_COL; gj++) begin : g_deskew
    localparam int D = MAC_COL - 1 - gj;
    if (D == 0) begin : g_direct
      assign w_col_out[gj] = w_psum[MAC_ROW][gj];
    end else begin : g_dly
      logic signed [OW-1:0] r_dd [D];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < D; k++) r_dd[k] <= '0;
        end else begin
          r_dd[0] <= w_psum[MAC_ROW][gj];
          for (int k = 1; k < D; k++) r_dd[k] <= r_dd[k-1];
        end
      end
      assign w_col_out[gj] = r_dd[D-1];
    end
    assign w_col_packed[gj*OW +: OW] = w_col_out[gj];
  end

  // The last flag rides a plain delay line matched to the array latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < LAT - 1; k++) r_last_sr[k] <= 1'b0;
      r_ofmap_valid <= 1'b0;
      r_ofmap_last  <= 1'b0;
      r_ofmap_data  <= '0;
    end else begin
      r_last_sr[0] <= w_accept & bus.ifmap_last;
      for (int k = 1; k < LAT - 1; k++) r_last_sr[k] <= r_last_sr[k-1];
      r_ofmap_valid <= w_vld[MAC_ROW-1][MAC_COL];
      r_ofmap_last  <= r_last_sr[LAT-2];
      if (w_vld[MAC_ROW-1][MAC_COL]) r_ofmap_data <= w_col_packed;
    end
  end
endmodule

// File: doc/mac_array_ws.md
MAC_ARRAY_WS -- requirements
Module: mac_array_ws

Interface
REQ-001 SHALL have parameter MAC_ROW, default 16, reduction depth (PE rows).
REQ-002 SHALL have parameter MAC_COL, default 16, output channels (PE columns).
REQ-003 SHALL have parameter IFMAP_BITWIDTH, default 16, signed activation width.
REQ-004 SHALL have parameter W_BITWIDTH, default 8, signed weight width.
REQ-005 SHALL have parameter OFMAP_BITWIDTH, default 32, signed result width.
REQ-006 SHALL have parameter SATURATE, default 1, 1 = clamp results, 0 = two's-complement wrap.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 w_load_valid  in  1  weight row beat valid.
REQ-010 w_load_ready  out  1  shadow weight bank can accept a beat.
REQ-011 w_load_data  in  MAC_COL*W_BITWIDTH  one weight row, column c in slice c.
REQ-012 ifmap_valid  in  1  activation vector valid.
REQ-013 ifmap_ready  out  1  array accepts an activation vector.
REQ-014 ifmap_data  in  MAC_ROW*IFMAP_BITWIDTH  unskewed activation vector, row r in slice r.
REQ-015 ifmap_last  in  1  marks final vector of a tile.
REQ-016 ofmap_valid  out  1  result vector valid; no backpressure.
REQ-017 ofmap_data  out  MAC_COL*OFMAP_BITWIDTH  deskewed result vector.
REQ-018 ofmap_last  out  1  result of the vector accepted with ifmap_last.
REQ-019 busy  out  1  state is not EMPTY, or a vector is in flight.

Function
REQ-020 Weight loading SHALL be double-buffered: a beat loads when w_load_valid and w_load_ready are both high, and row counter 0..MAC_ROW-1 selects the shadow row.
REQ-021 After beat MAC_ROW-1, shadow_full SHALL set and w_load_ready SHALL drop until swap; the counter wraps to 0.
REQ-022 Swap (shadow to active, all PEs, one cycle) SHALL occur only when shadow_full is set, state is EMPTY or DRAIN-complete, and no vector is in flight; swap clears shadow_full.
REQ-023 FSM states SHALL be EMPTY (no active weights), ACTIVE, DRAIN, and SWAP.
REQ-024 FSM transitions SHALL be: EMPTY->SWAP when shadow_full; SWAP->ACTIVE; ACTIVE->DRAIN on accepted ifmap_last; DRAIN->SWAP when in-flight count is 0 and shadow_full; DRAIN->ACTIVE when in-flight count is 0 and not shadow_full.
REQ-025 ifmap_ready SHALL be high only in ACTIVE.
REQ-026 Input skew: row r SHALL be delayed r cycles before entering PE column 0.
REQ-027 Output deskew: column c SHALL be delayed MAC_COL-1-c cycles, so all columns of a vector emerge together.
REQ-028 Fixed latency LAT = MAC_ROW + MAC_COL: a vector accepted at cycle t SHALL give ofmap_valid at t+LAT; results are in order, with one per accepted vector.
REQ-029 ofmap_data[c] SHALL equal the sum over r of ifmap[r]*w[r][c], signed, with products sign-extended to OFMAP_BITWIDTH.
REQ-030 SATURATE=1: each partial sum SHALL clamp to [-2^(OFMAP_BITWIDTH-1), 2^(OFMAP_BITWIDTH-1)-1]; SATURATE=0: each partial sum SHALL wrap.
REQ-031 Back-to-back vectors SHALL sustain one per cycle in ACTIVE.
REQ-032 Weight beats SHALL be accepted during ACTIVE/DRAIN streaming without disturbing active weights.
REQ-033 In-flight counter SHALL be 0..LAT, incrementing on accept and decrementing on ofmap_valid; simultaneous accept and emit SHALL leave it unchanged.
REQ-034 Bubbles (ifmap_valid low) SHALL propagate as invalid slots; ofmap_valid stays low for them.

Reset
REQ-035 rstn low SHALL set state EMPTY, shadow_full 0, row counter 0, in-flight count 0, and all PE weights/partial sums/skew registers to 0.
REQ-036 Reset values SHALL be w_load_ready 1, ifmap_ready 0, ofmap_valid 0, ofmap_last 0, ofmap_data 0, busy 0.
REQ-037 Reset mid-operation SHALL discard in-flight vectors and partial weight loads; no ofmap_valid SHALL appear afterwards until new accepts.

Structure
REQ-038 Package mac_array_pkg SHALL hold the FSM state enum and a LAT helper function.
REQ-039 Sub-module mac_pe SHALL be the single PE: active and shadow weight registers, activation pass-through, valid pass-through, and saturating accumulate.

Verification (MAC_ROW=MAC_COL=4, LAT=8)
REQ-040 Reset, then load 4 identity weight rows, then vector [1,2,3,4] -> ofmap [1,2,3,4] exactly 8 cycles after accept.
REQ-041 Stream 20 back-to-back random vectors -> 20 in-order results matching the golden model, one per cycle.
REQ-042 All weights 127 and activations 32767, SATURATE=1, OFMAP_BITWIDTH=16 -> every column equals 32767; with SATURATE=0, the wrapped value.
REQ-043 Load a second bank during streaming, then ifmap_last -> ifmap_ready low for the drain, swap, and later results use the new weights; ofmap_last coincides with the last old result.
REQ-044 Assert rstn low with 3 vectors in flight -> no ofmap_valid afterwards, state EMPTY, w_load_ready 1.
REQ-045 Pulse ifmap_valid every other cycle -> ofmap_valid pattern equals the input pattern delayed 8 cycles.
